// File: rtl/pe_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// pe_writeback_arbiter
//
// Shares the single write port of the output-feature-map SRAM between the
// NUM_LINES output lines of the PE array. Each line delivers one output plane
// of size_out*size_out results. At most one line is granted per cycle, chosen
// round-robin. The granted word is written at the plane-relative address
// line*plane + count[line]. When every line has delivered its full plane, a
// one-cycle done pulse is raised.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   reset        : synchronous, active-low reset
//   start        : one-cycle pulse that begins a pass (honoured only in IDLE)
//   size_out     : output map width, captured on an accepted start
//   line_valid   : per-line "result available"
//   line_data    : line i result at [i*DATA_WIDTH +: DATA_WIDTH]
//   line_ready   : combinational one-hot grant; a transfer is valid & ready
//   sram_stall   : SRAM cannot take a write this cycle (suppresses all grants)
//   sram_wr_en   : registered write strobe
//   sram_addr    : registered write address
//   sram_wr_data : registered write data
//   busy         : high while the pass is running
//   done         : one-cycle pulse when the pass completes
// ---------------------------------------------------------------------------
module pe_writeback_arbiter #(
    parameter int NUM_LINES  = 6,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [7:0]                      size_out,
    input  logic [NUM_LINES-1:0]            line_valid,
    input  logic [NUM_LINES*DATA_WIDTH-1:0] line_data,
    output logic [NUM_LINES-1:0]            line_ready,
    input  logic                            sram_stall,
    output logic                            sram_wr_en,
    output logic [ADDR_WIDTH-1:0]           sram_addr,
    output logic [DATA_WIDTH-1:0]           sram_wr_data,
    output logic                            busy,
    output logic                            done
);

    localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [15:0]             plane_reg;
    logic [15:0]             count_reg [NUM_LINES];
    logic [IDX_W-1:0]        rr_reg;
    logic                    wr_en_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wr_data_reg;
    logic                    busy_reg;
    logic                    done_reg;

    // Per-line views of the packed data bus and per-line status.
    logic [DATA_WIDTH-1:0]   data_lane [NUM_LINES];
    logic [NUM_LINES-1:0]    line_fin;
    logic [NUM_LINES-1:0]    eligible;
    logic                    all_fin;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            assign data_lane[gi] = line_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign line_fin[gi]  = (count_reg[gi] == plane_reg);
            // A finished line is never eligible, so its valid is ignored.
            assign eligible[gi]  = (state_reg == ST_RUN) && line_valid[gi]
                                   && (count_reg[gi] < plane_reg) && !sram_stall;
        end
    endgenerate

    assign all_fin = &line_fin;

    // -----------------------------------------------------------------------
    // Round-robin grant: scan from rr_reg upward, wrapping at NUM_LINES, and
    // take the first eligible line.
    // -----------------------------------------------------------------------
    logic [NUM_LINES-1:0]    grant_vec;
    logic                    grant_any;
    logic [IDX_W-1:0]        grant_idx;

    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        grant_vec = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            idx = int'(rr_reg) + k;
            if (idx >= NUM_LINES) begin
                idx = idx - NUM_LINES;
            end
            cand = IDX_W'(idx);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    assign line_ready = grant_vec;

    // -----------------------------------------------------------------------
    // Write address / data / pointer for the granted line.
    // The product is formed in 32 bits and then truncated, so an oversized
    // configuration simply wraps the address.
    // -----------------------------------------------------------------------
    logic [15:0]             count_sel;
    logic [31:0]             addr_wide;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [DATA_WIDTH-1:0]   data_next;
    logic [IDX_W-1:0]        rr_next;

    always_comb begin
        count_sel = count_reg[grant_idx];
        addr_wide = (32'(grant_idx) * 32'(plane_reg)) + 32'(count_sel);
        addr_next = ADDR_WIDTH'(addr_wide);
        data_next = data_lane[grant_idx];
        rr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end

    // -----------------------------------------------------------------------
    // Control FSM and registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            plane_reg   <= '0;
            rr_reg      <= '0;
            wr_en_reg   <= 1'b0;
            addr_reg    <= '0;
            wr_data_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                count_reg[i] <= '0;
            end
        end else begin
            // Strobes default low; address and data hold between writes.
            wr_en_reg <= 1'b0;
            done_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        plane_reg <= 16'(size_out) * 16'(size_out);
                        rr_reg    <= '0;
                        for (int i = 0; i < NUM_LINES; i++) begin
                            count_reg[i] <= '0;
                        end
                        if (size_out == 8'd0) begin
                            // Empty plane: nothing to write, finish at once.
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (all_fin) begin
                        // Counters were bumped by the last transfer on the
                        // previous edge, so completion lands one cycle later.
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else if (grant_any) begin
                        // grant_any already implies line_valid & line_ready.
                        wr_en_reg            <= 1'b1;
                        addr_reg             <= addr_next;
                        wr_data_reg          <= data_next;
                        count_reg[grant_idx] <= count_sel + 16'd1;
                        rr_reg               <= rr_next;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign sram_wr_en   = wr_en_reg;
    assign sram_addr    = addr_reg;
    assign sram_wr_data = wr_data_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_pe_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pe_writeback_arbiter
//
// Directed bench for pe_writeback_arbiter with NUM_LINES=6, 16-bit data and
// addresses. Line i drives the constant word 16'hD000+i so the written data
// identifies the granted line. Inputs change 1 ns after the rising edge and
// outputs are read at that point.
// ---------------------------------------------------------------------------
module tb_pe_writeback_arbiter;

    localparam int NL = 6;
    localparam int DW = 16;
    localparam int AW = 16;

    logic              clk;
    logic              reset;
    logic              start;
    logic [7:0]        size_out;
    logic [NL-1:0]     line_valid;
    logic [NL*DW-1:0]  line_data;
    logic [NL-1:0]     line_ready;
    logic              sram_stall;
    logic              sram_wr_en;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wr_data;
    logic              busy;
    logic              done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pe_writeback_arbiter #(
        .NUM_LINES  (NL),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .size_out     (size_out),
        .line_valid   (line_valid),
        .line_data    (line_data),
        .line_ready   (line_ready),
        .sram_stall   (sram_stall),
        .sram_wr_en   (sram_wr_en),
        .sram_addr    (sram_addr),
        .sram_wr_data (sram_wr_data),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until done, counting writes; checks write count and that done came.
    task automatic run_to_done(input string tag, input int exp_writes);
        int  n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (sram_wr_en) n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_writes"}, n, exp_writes);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        size_out   = 8'd0;
        line_valid = '0;
        sram_stall = 1'b0;
        for (int i = 0; i < NL; i++) begin
            line_data[i*DW +: DW] = 16'(16'hD000 + i);
        end

        // ---- Reset state ----
        tick();
        tick();
        chk("rst_wr_en", 32'(sram_wr_en), 0);
        chk("rst_addr",  32'(sram_addr), 0);
        chk("rst_data",  32'(sram_wr_data), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        reset      = 1'b1;
        line_valid = 6'h3F;
        #1;
        chk("idle_ready", 32'(line_ready), 0);

        // ---- Test 1: size 2, all lines valid, 24 writes in order ----
        start    = 1'b1;
        size_out = 8'd2;
        tick();
        start = 1'b0;
        chk("t1_busy", 32'(busy), 1);
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("t1_ready_%0d", k), 32'(line_ready), 32'(1 << (k % 6)));
            tick();
            chk($sformatf("t1_wr_%0d", k), 32'(sram_wr_en), 1);
            chk($sformatf("t1_addr_%0d", k), 32'(sram_addr), 32'((k % 6) * 4 + k / 6));
            chk($sformatf("t1_data_%0d", k), 32'(sram_wr_data), 32'(16'hD000 + (k % 6)));
        end
        chk("t1_busy_last", 32'(busy), 1);
        chk("t1_done_early", 32'(done), 0);
        chk("t1_ready_fin", 32'(line_ready), 0);
        tick();
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_off", 32'(busy), 0);
        chk("t1_wr_off", 32'(sram_wr_en), 0);
        tick();
        chk("t1_done_pulse", 32'(done), 0);

        // ---- Test 2: only line 5 valid, then the rest ----
        line_valid = 6'h20;
        start      = 1'b1;
        size_out   = 8'd2;
        tick();
        start = 1'b0;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("t2_ready5_%0d", r), 32'(line_ready), 32'h20);
            tick();
            chk($sformatf("t2_addr5_%0d", r), 32'(sram_addr), 32'(20 + r));
            chk($sformatf("t2_data5_%0d", r), 32'(sram_wr_data), 32'hD005);
        end
        chk("t2_ready_none", 32'(line_ready), 0);
        tick();
        chk("t2_wr_idle", 32'(sram_wr_en), 0);
        chk("t2_busy", 32'(busy), 1);
        chk("t2_no_done", 32'(done), 0);
        tick();
        line_valid = 6'h3F;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 5; j++) begin
                #1;
                chk($sformatf("t2_ready_%0d_%0d", r, j), 32'(line_ready), 32'(1 << j));
                tick();
                chk($sformatf("t2_addr_%0d_%0d", r, j), 32'(sram_addr), 32'(j * 4 + r));
            end
        end
        tick();
        chk("t2_done", 32'(done), 1);
        tick();

        // ---- Test 3: stall for 3 cycles mid-pass ----
        start    = 1'b1;
        size_out = 8'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("t3_pre_addr", 32'(sram_addr), 8);
        sram_stall = 1'b1;
        #1;
        chk("t3_stall_ready", 32'(line_ready), 0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("t3_stall_wr_%0d", s), 32'(sram_wr_en), 0);
            chk($sformatf("t3_stall_addr_%0d", s), 32'(sram_addr), 8);
            chk($sformatf("t3_stall_rdy_%0d", s), 32'(line_ready), 0);
        end
        sram_stall = 1'b0;
        #1;
        chk("t3_resume_ready", 32'(line_ready), 32'h08);
        tick();
        chk("t3_resume_addr", 32'(sram_addr), 12);
        chk("t3_resume_data", 32'(sram_wr_data), 32'hD003);
        run_to_done("t3", 20);
        tick();

        // ---- Test 4: size_out = 0 ----
        start    = 1'b1;
        size_out = 8'd0;
        #1;
        chk("t4_idle_ready", 32'(line_ready), 0);
        tick();
        start = 1'b0;
        chk("t4_done", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_wr", 32'(sram_wr_en), 0);
        chk("t4_ready", 32'(line_ready), 0);
        tick();
        chk("t4_done_pulse", 32'(done), 0);
        chk("t4_ready2", 32'(line_ready), 0);

        // ---- Test 5: reset mid-pass, then size_out = 1 ----
        start    = 1'b1;
        size_out = 8'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("t5_wr_before", 32'(sram_wr_en), 1);
        reset = 1'b0;
        tick();
        chk("t5_rst_wr", 32'(sram_wr_en), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_addr", 32'(sram_addr), 0);
        chk("t5_rst_ready", 32'(line_ready), 0);
        reset    = 1'b1;
        start    = 1'b1;
        size_out = 8'd1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("t5_wr_%0d", k), 32'(sram_wr_en), 1);
            chk($sformatf("t5_addr_%0d", k), 32'(sram_addr), k);
            chk($sformatf("t5_data_%0d", k), 32'(sram_wr_data), 32'(16'hD000 + k));
        end
        tick();
        chk("t5_done", 32'(done), 1);
        tick();

        // ---- Test 6: start during RUN is ignored ----
        start    = 1'b1;
        size_out = 8'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        start    = 1'b1;
        size_out = 8'd3;
        tick();
        start    = 1'b0;
        size_out = 8'd2;
        chk("t6_wr_during_start", 32'(sram_wr_en), 1);
        run_to_done("t6", 18);
        tick();
        chk("t6_idle_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
